// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: word size, NOP encoding, queue entry layout
// and the pointer-width helper used by the fetch queue.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INCR   = 32'd1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  // What happens to an instruction-memory response in the current cycle.
  typedef enum logic [1:0] {
    RESP_IDLE   = 2'd0,
    RESP_PUSH   = 2'd1,
    RESP_DROP   = 2'd2,
    RESP_SQUASH = 2'd3
  } resp_action_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Instruction-memory request/response bus between the fetch front end (master)
// and the instruction memory (slave).
interface fetch_prefetch_queue_if;
  import cpu_pkg::*;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// In-order {pc, instr} queue with show-ahead head, occupancy count and a
// single-cycle flush that empties the queue and rewinds both pointers.
module fetch_queue_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = ptr_width(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fq_entry_t        wr_entry,
  input  logic             pop,
  output fq_entry_t        head,
  output logic [CNT_W-1:0] count
);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             empty;
  logic             push_en;
  logic             pop_en;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_en = push && !flush;
  assign pop_en  = pop && !flush && !empty;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset: entries are only observable once count covers them.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= wr_entry;
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push_en && full && !pop_en));

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: issues word-addressed PCs to instruction memory under a
// credit limit, buffers responses in order, and flushes on branch redirect.
module fetch_prefetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'd0
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_prefetch_queue_if.master imem,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   stall,
  output logic                   if_valid,
  output logic [XLEN-1:0]        if_pc,
  output logic [XLEN-1:0]        if_instruction
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   credit_used;
  logic             issue;
  logic             issue_fire;
  logic             pop;
  resp_action_e     resp_action;
  fq_entry_t        wr_entry;
  fq_entry_t        head;

  // Every accepted request owns a queue slot, so the queue can never overflow.
  assign credit_used = {1'b0, outstanding} + {1'b0, count};
  assign issue       = !reset && !redirect_valid && (credit_used < (CNT_W+1)'(DEPTH));
  assign issue_fire  = issue && imem.imem_req_ready;

  assign imem.imem_req_valid = issue;
  assign imem.imem_req_addr  = fetch_pc;

  always_comb begin
    resp_action = RESP_IDLE;
    if (imem.imem_resp_valid) begin
      if (redirect_valid)       resp_action = RESP_SQUASH;
      else if (drop_cnt != '0)  resp_action = RESP_DROP;
      else                      resp_action = RESP_PUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      unique case ({issue_fire, imem.imem_resp_valid})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase

      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        // The response arriving now is squashed directly, so it is not counted.
        drop_cnt <= outstanding - CNT_W'(imem.imem_resp_valid);
      end else begin
        if (issue_fire)                fetch_pc <= fetch_pc + PC_INCR;
        if (resp_action == RESP_PUSH)  resp_pc  <= resp_pc + PC_INCR;
        if (resp_action == RESP_DROP)  drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = resp_pc;
    wr_entry.instr = imem.imem_resp_data;
  end

  assign pop = if_valid && !stall;

  fetch_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (resp_action == RESP_PUSH),
    .wr_entry (wr_entry),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  always_comb begin
    if_valid       = (count != '0);
    if_pc          = '0;
    if_instruction = NOP_INSTR;
    if (if_valid) begin
      if_pc          = head.pc;
      if_instruction = head.instr;
    end
  end

  a_resp_has_request: assert property (@(posedge clk) disable iff (reset)
    imem.imem_resp_valid |-> (outstanding != '0));

  a_credit_bound: assert property (@(posedge clk) disable iff (reset)
    credit_used <= (CNT_W+1)'(DEPTH));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with an in-order fixed-latency
// instruction memory returning instr = addr + 0x100.
module tb_fetch_prefetch_queue;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;

  fetch_prefetch_queue_if bus ();

  fetch_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'd0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem           (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instruction (if_instruction)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;
  int unsigned lat   = 1;
  logic [31:0] pend_addr [$];
  int unsigned pend_due  [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; the memory model retires the response it presented,
  // records any accepted request, then presents the oldest due response.
  task automatic tick();
    logic        fire;
    logic [31:0] faddr;
    logic        was_reset;
    @(negedge clk);
    fire      = bus.imem_req_valid && bus.imem_req_ready;
    faddr     = bus.imem_req_addr;
    was_reset = reset;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.imem_resp_valid && pend_addr.size() > 0) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (was_reset) begin
      pend_addr.delete();
      pend_due.delete();
    end else if (fire) begin
      pend_addr.push_back(faddr);
      pend_due.push_back(cyc + lat - 1);
    end
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = pend_addr[0] + 32'h100;
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
    end
  endtask

  task automatic do_reset(input int unsigned new_lat);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    lat            = new_lat;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check_eq({tag, "_valid"}, 32'(if_valid), 32'd1);
    check_eq({tag, "_pc"}, if_pc, pc);
    check_eq({tag, "_instr"}, if_instruction, pc + 32'h100);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset               = 1'b1;
    redirect_valid      = 1'b0;
    redirect_pc         = 32'h0;
    stall               = 1'b0;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;

    // Reset state
    tick();
    tick();
    #1;
    check_eq("rst_if_valid", 32'(if_valid), 32'd0);
    check_eq("rst_if_pc", if_pc, 32'h0);
    check_eq("rst_if_instr", if_instruction, NOP_INSTR);
    check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);

    // Streaming with 1-cycle memory: first head two cycles after release
    reset = 1'b0;
    #1;
    check_eq("s_req_valid0", 32'(bus.imem_req_valid), 32'd1);
    check_eq("s_req_addr0", bus.imem_req_addr, 32'h0);
    tick();
    #1;
    check_eq("s_if_valid1", 32'(if_valid), 32'd0);
    check_eq("s_req_addr1", bus.imem_req_addr, 32'h1);
    tick();
    #1;
    check_head("s_head0", 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      #1;
      check_head("s_head", 32'(k));
    end

    // Stall 6 cycles with head pc 5: head holds, credit runs out after 2 issues
    for (int i = 0; i < 6; i++) begin
      stall = 1'b1;
      #1;
      check_eq("st_hold_pc", if_pc, 32'h5);
      check_eq("st_req_valid", 32'(bus.imem_req_valid), (i < 2) ? 32'd1 : 32'd0);
      tick();
    end
    stall = 1'b0;
    for (int k = 5; k <= 12; k++) begin
      #1;
      check_head("st_resume", 32'(k));
      tick();
    end

    // Latency 3: redirect to 0x40 with 3 requests outstanding
    do_reset(3);
    #1;
    check_eq("r3_req_addr0", bus.imem_req_addr, 32'h0);
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    check_eq("r3_redir_no_issue", 32'(bus.imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("r3_if_valid_a", 32'(if_valid), 32'd0);
    check_eq("r3_drop_cnt_2", 32'(dut.drop_cnt), 32'd2);
    check_eq("r3_req_addr", bus.imem_req_addr, 32'h40);
    tick();
    #1;
    check_eq("r3_if_valid_b", 32'(if_valid), 32'd0);
    tick();
    #1;
    check_eq("r3_if_valid_c", 32'(if_valid), 32'd0);
    check_eq("r3_drop_cnt_0", 32'(dut.drop_cnt), 32'd0);
    tick();
    #1;
    check_eq("r3_if_valid_d", 32'(if_valid), 32'd0);
    tick();
    #1;
    check_head("r3_head40", 32'h40);
    tick();
    #1;
    check_head("r3_head41", 32'h41);

    // Redirect coinciding with a response while stalled
    do_reset(1);
    tick();
    tick();
    tick();
    #1;
    check_eq("rs_pre_valid", 32'(if_valid), 32'd1);
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    #1;
    check_eq("rs_no_issue", 32'(bus.imem_req_valid), 32'd0);
    tick();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check_eq("rs_flushed", 32'(if_valid), 32'd0);
    check_eq("rs_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check_eq("rs_req_addr", bus.imem_req_addr, 32'h80);
    tick();
    #1;
    check_eq("rs_if_valid_b", 32'(if_valid), 32'd0);
    tick();
    #1;
    check_head("rs_head80", 32'h80);

    // Redirect to the top of the address space: fetch PC wraps to 0
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("w_req_addr_top", bus.imem_req_addr, 32'hFFFF_FFFF);
    check_eq("w_if_valid", 32'(if_valid), 32'd0);
    tick();
    #1;
    check_eq("w_req_addr_wrap", bus.imem_req_addr, 32'h0);
    tick();
    #1;
    check_eq("w_head_top_pc", if_pc, 32'hFFFF_FFFF);
    check_eq("w_head_top_instr", if_instruction, 32'h0000_00FF);
    tick();
    #1;
    check_head("w_head_zero", 32'h0);

    // Reset mid-flight: 2 outstanding, 2 queued, credit exhausted
    do_reset(3);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #1;
    check_eq("mr_credit_full", 32'(bus.imem_req_valid), 32'd0);
    check_eq("mr_pre_pc", if_pc, 32'h0);
    check_eq("mr_outstanding", 32'(dut.outstanding), 32'd2);
    reset = 1'b1;
    stall = 1'b0;
    #1;
    check_eq("mr_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("mr_if_valid", 32'(if_valid), 32'd0);
    check_eq("mr_if_pc", if_pc, 32'h0);
    check_eq("mr_if_instr", if_instruction, NOP_INSTR);
    check_eq("mr_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check_eq("mr_req_addr", bus.imem_req_addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check_eq("mr_no_stale", 32'(if_valid), 32'd0);
    end
    tick();
    #1;
    check_head("mr_restart", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
